// File: rtl/usrrelu_prep.sv
// ReLU / leaky-ReLU pre-stage: registers mux select and both operands per element
// behind a 2-entry skid FIFO, and tags the last element of each vector.
module usrrelu_prep #(
    parameter int WIDTH   = 64,
    parameter int VEC_LEN = 16,
    parameter int SHW     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             cfg_mode,
    input  logic [SHW-1:0]   cfg_shift,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sel,
    output logic [WIDTH-1:0] out_i0,
    output logic [WIDTH-1:0] out_i1,
    output logic             out_last
);

    localparam int IW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;

    typedef struct packed {
        logic             sel;
        logic             last;
        logic [WIDTH-1:0] i0;
        logic [WIDTH-1:0] i1;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e             occ_q, occ_d;
    entry_t           head_q, head_d;
    entry_t           tail_q, tail_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             mode_q, mode_d;
    logic [SHW-1:0]   shift_q, shift_d;

    logic                    accept;
    logic                    consume;
    logic                    first;
    logic                    is_last;
    logic                    eff_mode;
    logic [SHW-1:0]          eff_shift;
    logic                    sat;
    logic signed [WIDTH-1:0] x_s;
    entry_t                  new_e;

    assign in_ready  = !rst && (occ_q != FULL);
    assign out_valid = (occ_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    assign out_sel   = head_q.sel;
    assign out_last  = head_q.last;
    assign out_i0    = head_q.i0;
    assign out_i1    = head_q.i1;

    // The first element of a vector uses the live cfg; the rest use the latched copy.
    assign first     = (idx_q == '0);
    assign is_last   = (idx_q == IW'(VEC_LEN - 1));
    assign eff_mode  = first ? cfg_mode : mode_q;
    assign eff_shift = first ? cfg_shift : shift_q;
    assign sat       = (32'(eff_shift) >= 32'(WIDTH));
    assign x_s       = in_data;

    always_comb begin
        new_e      = '0;
        new_e.sel  = ~in_data[WIDTH-1];
        new_e.last = is_last;
        new_e.i1   = in_data;
        if (eff_mode) begin
            if (sat) begin
                new_e.i0 = {WIDTH{in_data[WIDTH-1]}};
            end else begin
                new_e.i0 = x_s >>> eff_shift;
            end
        end
    end

    always_comb begin
        idx_d   = idx_q;
        mode_d  = mode_q;
        shift_d = shift_q;
        if (accept) begin
            idx_d = is_last ? '0 : idx_q + IW'(1);
            if (first) begin
                mode_d  = cfg_mode;
                shift_d = cfg_shift;
            end
        end
    end

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        unique case (occ_q)
            EMPTY: begin
                if (accept) begin
                    head_d = new_e;
                    occ_d  = HALF;
                end
            end
            HALF: begin
                if (accept && consume) begin
                    head_d = new_e;
                end else if (accept) begin
                    tail_d = new_e;
                    occ_d  = FULL;
                end else if (consume) begin
                    occ_d  = EMPTY;
                end
            end
            FULL: begin
                if (consume) begin
                    head_d = tail_q;
                    occ_d  = HALF;
                end
            end
            default: occ_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q   <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
            shift_q <= '0;
        end else begin
            occ_q   <= occ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: tb/tb_usrrelu_prep.sv
// Directed and random stimulus for usrrelu_prep against a queue-based
// reference model using arithmetic floor division for the leaky branch.
`timescale 1ns/1ps
module tb_usrrelu_prep;

    localparam int W   = 64;
    localparam int VEC = 4;
    localparam int SHW = 7;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_data = '0;
    logic           cfg_mode = 1'b0;
    logic [SHW-1:0] cfg_shift = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic           out_sel;
    logic [W-1:0]   out_i0;
    logic [W-1:0]   out_i1;
    logic           out_last;

    usrrelu_prep #(.WIDTH(W), .VEC_LEN(VEC), .SHW(SHW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .cfg_mode(cfg_mode), .cfg_shift(cfg_shift),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sel(out_sel), .out_i0(out_i0), .out_i1(out_i1),
        .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic   sel;
        logic   last;
        longint i0;
        longint i1;
    } exp_t;

    exp_t   q[$];
    int     m_idx = 0;
    logic   a_mode = 1'b0;
    int     a_shift = 0;
    logic   zero_out = 1'b1;
    int     nvec = 0;
    int     nfail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic longint floor_shr(input longint x, input int s);
        longint p, r;
        if (s >= 63) return (x < 0) ? -64'sd1 : 64'sd0;
        p = longint'(1) << s;
        r = x / p;
        if (x < 0 && r * p != x) r = r - 1;
        return r;
    endfunction

    function automatic void model_clear();
        q.delete();
        m_idx    = 0;
        a_mode   = 1'b0;
        a_shift  = 0;
        zero_out = 1'b1;
    endfunction

    function automatic void model_accept(input longint x, input logic m, input int s);
        exp_t e;
        if (m_idx == 0) begin
            a_mode  = m;
            a_shift = s;
        end
        e.sel  = (x >= 0);
        e.i1   = x;
        e.i0   = a_mode ? floor_shr(x, a_shift) : 64'sd0;
        e.last = (m_idx == VEC - 1);
        m_idx  = (m_idx + 1) % VEC;
        q.push_back(e);
        zero_out = 1'b0;
    endfunction

    task automatic check_outs();
        chk("in_ready", 64'(in_ready), 64'(!rst && q.size() != 2));
        chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
        if (q.size() > 0) begin
            chk("sel", 64'(out_sel), 64'(q[0].sel));
            chk("i0", out_i0, q[0].i0);
            chk("i1", out_i1, q[0].i1);
            chk("last", 64'(out_last), 64'(q[0].last));
        end else if (zero_out) begin
            chk("rst_sel", 64'(out_sel), 64'd0);
            chk("rst_i0", out_i0, 64'd0);
            chk("rst_i1", out_i1, 64'd0);
            chk("rst_last", 64'(out_last), 64'd0);
        end
    endtask

    task automatic step(input logic v, input longint x, input logic m,
                        input int s, input logic ordy);
        logic acc, con;
        @(negedge clk);
        in_valid  = v;
        in_data   = x;
        cfg_mode  = m;
        cfg_shift = SHW'(s);
        out_ready = ordy;
        #1;
        check_outs();
        acc = v && !rst && q.size() < 2;
        con = ordy && q.size() > 0;
        @(posedge clk);
        if (con) void'(q.pop_front());
        if (acc) model_accept(x, m, s);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        #1;
        model_clear();
        check_outs();
        repeat (n) begin
            @(negedge clk);
            #1;
            check_outs();
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // reset held with in_valid high
        do_reset(3);
        step(1'b0, 0, 1'b0, 0, 1'b1);

        // ReLU
        do_reset(1);
        step(1'b1, 5, 1'b0, 0, 1'b1);
        step(1'b1, -3, 1'b0, 0, 1'b1);
        step(1'b1, 0, 1'b0, 0, 1'b1);
        step(1'b0, 0, 1'b0, 0, 1'b1);

        // leaky, normal and saturating shifts
        do_reset(1);
        step(1'b1, -8, 1'b1, 2, 1'b1);
        step(1'b0, 0, 1'b1, 2, 1'b1);
        do_reset(1);
        step(1'b1, -8, 1'b1, 70, 1'b1);
        step(1'b1, 8, 1'b1, 70, 1'b1);
        step(1'b1, 64'sh8000_0000_0000_0000, 1'b1, 63, 1'b1);
        step(1'b0, 0, 1'b0, 0, 1'b1);

        // backpressure
        do_reset(1);
        for (int i = 0; i < 4; i++)
            step(1'b1, longint'({$urandom, $urandom}), 1'b1, 1, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 0, 1'b0, 0, 1'b1);

        // vector boundaries with mid-vector cfg change
        do_reset(1);
        for (int i = 0; i < 8; i++)
            step(1'b1, -longint'($urandom_range(1, 100000)),
                 (i < 2) ? 1'b1 : 1'b0, 1, 1'b1);
        step(1'b0, 0, 1'b0, 0, 1'b1);

        // async reset with FIFO full and idx=2
        step(1'b1, 11, 1'b0, 0, 1'b0);
        step(1'b1, -12, 1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0, 0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        check_outs();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, -100, 1'b1, 3, 1'b1);
        step(1'b0, 0, 1'b0, 0, 1'b1);

        // random traffic
        for (int i = 0; i < 300; i++) begin
            longint x;
            x = ($urandom_range(0, 3) == 0) ? longint'($urandom_range(0, 20)) - 10
                                            : longint'({$urandom, $urandom});
            step($urandom_range(0, 3) != 0, x, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 80), $urandom_range(0, 2) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
